data_memory_be: RTL and testbench
=================================

// Module: data_memory_be
// PURPOSE
//   Parametrised byte-addressed, little-endian data memory for the Beta datapath.
//   Sits behind the ALU/address stage and serves load/store requests of byte, half and word size.
//   Adds a valid/ready request interface, in-order responses after a fixed pipelined read latency,
//   sign/zero extension, and error reporting for misaligned or out-of-range requests.
//   Optionally clears its contents after reset.
// PARAMETERS
//   DEPTH_BYTES  4096  memory size in bytes; must be a multiple of 4
//   ADDR_W       32    request address width
//   READ_LAT     1     cycles from request acceptance to rsp_valid; legal range 1..4
//   INIT_CLEAR   1     1: zero the whole array after reset, one word per cycle; 0: skip straight to RUN
// PORTS
//   clock      in   1       rising-edge clock
//   reset_n    in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       request accepted when req_valid && req_ready
//   req_we     in   1       1 store, 0 load
//   req_size   in   2       0 byte, 1 half, 2 word; 3 is illegal
//   req_signed in   1       loads only: 1 sign-extend, 0 zero-extend
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      store data; low bytes are used for byte/half stores
//   rsp_valid  out  1       one-cycle pulse, one per accepted request
//   rsp_rdata  out  32      extended load data; 0 for stores and for errors
//   rsp_err    out  1       request was misaligned, out of range, or used size 3
// BEHAVIOUR
//   Reset (async assert, sync deassert use):
//     - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//     - Pipeline valids clear; FSM goes to INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
//     - Array contents are not reset.
//   FSM:
//     - INIT: word counter runs 0..DEPTH_BYTES/4-1 and writes 0 each cycle; req_ready=0.
//       After the last word the FSM enters RUN on the next cycle.
//     - RUN: req_ready=1 every cycle, so the block accepts one request per cycle with full throughput.
//   Error check at acceptance:
//     - Error if size==3, or half with addr[0]!=0, or word with addr[1:0]!=0,
//       or addr+(1<<size) > DEPTH_BYTES (computed ADDR_W+1 wide, so no wrap).
//     - An erroring store does not modify the array.
//   Store: bytes addr..addr+(1<<size)-1 take req_wdata[7:0], [15:8], ... on the acceptance edge.
//   Load: read bytes {addr+3..addr}, masked to the size, then sign- or zero-extended to 32 bits.
//   Latency and ordering:
//     - A request accepted at edge N yields rsp_valid=1 for exactly one cycle after edge N+READ_LAT.
//     - Responses are in order, with no back-pressure on responses.
//   Hazards:
//     - A load accepted the cycle after a store to overlapping bytes returns the new data.
//     - Only one request is accepted per cycle, so there is no same-cycle read/write conflict.
//   Reset mid-operation: in-flight responses are dropped (no rsp_valid), and INIT restarts from word 0.
// TESTING
//   1. INIT_CLEAR=1, DEPTH_BYTES=64: release reset -> req_ready stays 0 for 16 cycles, then rises;
//      a load of word 0x3C returns 0.
//   2. Store word 0x8000_00FF at 0x10, then byte load 0x10 signed -> 0xFFFF_FFFF;
//      unsigned -> 0x0000_00FF; half load 0x12 signed -> 0xFFFF_8000.
//   3. Byte store 0xAB at 0x21 over word 0x1122_3344 at 0x20 -> word load 0x20 returns 0x1122_AB44.
//   4. Word load at 0x22, half store at 0x13, and size=3 -> rsp_err=1 and rsp_rdata=0 for each;
//      the array is unchanged.
//   5. DEPTH_BYTES=64: word load at 0x3C -> ok; half load at 0x3F -> err;
//      addr 0xFFFF_FFFC -> err (no wrap).
//   6. READ_LAT=3, back-to-back 5 loads -> 5 in-order rsp_valid pulses starting 3 cycles after the first;
//      assert reset_n low mid-stream -> no further rsp_valid.

Source files
------------

// File: rtl/data_memory_be.sv
`default_nettype none
// ============================================================================
// data_memory_be : byte-addressed little-endian data memory, valid/ready
//                  requests, pipelined in-order responses, error reporting
// Revision       : 1.0
// ============================================================================
module data_memory_be #(
  parameter int DEPTH_BYTES = 4096,
  parameter int ADDR_W      = 32,
  parameter int READ_LAT    = 1,
  parameter int INIT_CLEAR  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state;
  logic [IDX_W-1:0] init_cnt;
  logic [31:0] mem [WORDS];
  logic [31:0] rd_word;

  logic              accept;
  logic              req_err;
  logic [2:0]        nbytes;
  logic [ADDR_W:0]   req_end;
  logic [3:0]        be_base;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic              init_we;
  logic [IDX_W-1:0]  word_idx;

  logic        s0_valid, s0_err, s0_load, s0_signed;
  logic [1:0]  s0_off, s0_size;
  logic [31:0] shifted, ext, fmt;

  logic [READ_LAT-1:0]       pv, pe;
  logic [READ_LAT-1:0][31:0] pd;

  assign accept   = req_valid && req_ready;
  assign init_we  = (state == ST_INIT);
  assign word_idx = req_addr[IDX_W+1:2];

  // End address is one bit wider than the address so a request near the top
  // of the address space cannot wrap back into range.
  always_comb begin
    nbytes  = 3'd1 << req_size;
    req_end = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);
    req_err = (req_size == 2'd3)
           || ((req_size == 2'd1) && req_addr[0])
           || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
           || (req_end > (ADDR_W+1)'(DEPTH_BYTES));
    case (req_size)
      2'd0:    be_base = 4'b0001;
      2'd1:    be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    wr_be   = be_base << req_addr[1:0];
    wr_data = req_wdata << {req_addr[1:0], 3'b000};
    wr_en   = accept && req_we && !req_err;
  end

  // Array has no reset; the read port sees stores from earlier edges.
  always_ff @(posedge clock) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
    if (accept) rd_word <= mem[word_idx];
  end

  always_comb begin
    shifted = rd_word >> {s0_off, 3'b000};
    case (s0_size)
      2'd0:    ext = s0_signed ? {{24{shifted[7]}}, shifted[7:0]}
                               : {24'h0, shifted[7:0]};
      2'd1:    ext = s0_signed ? {{16{shifted[15]}}, shifted[15:0]}
                               : {16'h0, shifted[15:0]};
      default: ext = shifted;
    endcase
    fmt = (s0_load && !s0_err) ? ext : 32'h0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      s0_valid  <= 1'b0;
      s0_err    <= 1'b0;
      s0_load   <= 1'b0;
      s0_signed <= 1'b0;
      s0_off    <= 2'b00;
      s0_size   <= 2'b00;
      pv        <= '0;
      pe        <= '0;
      pd        <= '0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == IDX_W'(WORDS-1)) begin
          state     <= ST_RUN;
          req_ready <= 1'b1;
        end
      end else begin
        req_ready <= 1'b1;
      end

      s0_valid <= accept;
      if (accept) begin
        s0_err    <= req_err;
        s0_load   <= !req_we;
        s0_signed <= req_signed;
        s0_off    <= req_addr[1:0];
        s0_size   <= req_size;
      end

      for (int i = READ_LAT-1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pd[i] <= pd[i-1];
      end
      pv[0] <= s0_valid;
      pe[0] <= s0_valid && s0_err;
      pd[0] <= s0_valid ? fmt : 32'h0;
    end
  end

  assign rsp_valid = pv[READ_LAT-1];
  assign rsp_err   = pe[READ_LAT-1];
  assign rsp_rdata = pd[READ_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_data_memory_be.sv
`default_nettype none
// ============================================================================
// tb_data_memory_be : directed scoreboard bench for data_memory_be
// Revision          : 1.0
// ============================================================================
module tb_data_memory_be;

  localparam int DEPTH    = 64;
  localparam int AW       = 32;
  localparam int LAT      = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_memory_be #(
    .DEPTH_BYTES(DEPTH), .ADDR_W(AW), .READ_LAT(LAT), .INIT_CLEAR(1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   rsp_seen = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every response pops the oldest expectation.
  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      rsp_seen++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid data=%h err=%b, required none", rsp_rdata, rsp_err);
      end else begin
        mon_e = q.pop_front();
        if (rsp_rdata !== mon_e.data || rsp_err !== mon_e.err) begin
          failures++;
          $display("FAIL rsp_data: got data=%h err=%b, required data=%h err=%b",
                   rsp_rdata, rsp_err, mon_e.data, mon_e.err);
        end
        checks++;
        if (cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL rsp_latency: got cycle %0d, required cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Inputs are driven #1 after an edge; the request is accepted on the next edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] ed, input logic ee);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    check("req_ready_at_issue", {31'h0, req_ready}, 32'h1);
    @(posedge clock);
    #1;
    q.push_back('{ed, ee, cyc + LAT});
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain_queue_empty", q.size(), 32'h0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  int n_rdy;
  int seen_before;

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("reset_req_ready", {31'h0, req_ready}, 32'h0);
    check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // INIT clears 16 words before accepting requests
    wait_ready(n_rdy);
    check("init_cycles", n_rdy, 32'd16);
    issue(0, 2'd2, 0, 32'h3C, 32'h0, 32'h0, 1'b0);

    // store / extension
    issue(1, 2'd2, 0, 32'h10, 32'h8000_00FF, 32'h0, 1'b0);
    issue(0, 2'd0, 1, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0);
    issue(0, 2'd0, 0, 32'h10, 32'h0, 32'h0000_00FF, 1'b0);
    issue(0, 2'd1, 1, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0);
    issue(0, 2'd1, 0, 32'h12, 32'h0, 32'h0000_8000, 1'b0);

    // byte merge
    issue(1, 2'd2, 0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
    issue(1, 2'd0, 0, 32'h21, 32'h0000_00AB, 32'h0, 1'b0);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);

    // misaligned / illegal size, array untouched
    issue(0, 2'd2, 0, 32'h22, 32'h0, 32'h0, 1'b1);
    issue(1, 2'd1, 0, 32'h13, 32'h0000_BEEF, 32'h0, 1'b1);
    issue(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1'b1);
    issue(1, 2'd3, 0, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b1);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 32'h8000_00FF, 1'b0);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);

    // range boundaries
    issue(0, 2'd2, 0, 32'h3C, 32'h0, 32'h0, 1'b0);
    issue(0, 2'd1, 0, 32'h3F, 32'h0, 32'h0, 1'b1);
    issue(0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
    issue(0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 1'b1);
    issue(1, 2'd0, 0, 32'h3F, 32'h0000_0080, 32'h0, 1'b0);
    issue(0, 2'd0, 1, 32'h3F, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue(0, 2'd2, 0, 32'h3C, 32'h0, 32'h8000_0000, 1'b0);
    drain();

    // five back-to-back loads
    issue(0, 2'd2, 0, 32'h10, 32'h0, 32'h8000_00FF, 1'b0);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);
    issue(0, 2'd1, 0, 32'h12, 32'h0, 32'h0000_8000, 1'b0);
    issue(0, 2'd0, 1, 32'h21, 32'h0, 32'hFFFF_FFAB, 1'b0);
    issue(0, 2'd2, 0, 32'h3C, 32'h0, 32'h8000_0000, 1'b0);
    drain();

    // reset with responses in flight drops them and restarts INIT
    seen_before = rsp_seen;
    issue(0, 2'd2, 0, 32'h10, 32'h0, 32'h8000_00FF, 1'b0);
    issue(0, 2'd2, 0, 32'h20, 32'h0, 32'h1122_AB44, 1'b0);
    issue(0, 2'd2, 0, 32'h3C, 32'h0, 32'h8000_0000, 1'b0);
    reset_n = 1'b0;
    q.delete();
    repeat (3) @(posedge clock);
    #1;
    check("midreset_req_ready", {31'h0, req_ready}, 32'h0);
    reset_n = 1'b1;
    wait_ready(n_rdy);
    check("reinit_cycles", n_rdy, 32'd16);
    repeat (5) @(posedge clock);
    #1;
    check("dropped_responses", rsp_seen - seen_before, 32'h0);
    issue(0, 2'd2, 0, 32'h10, 32'h0, 32'h0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
